button_scan_controller: RTL and testbench

BUTTON_SCAN_CONTROLLER -- requirements
Module: button_scan_controller

---
 rtl/button_scan_pkg.sv | 29 ++
 rtl/button_scan_controller_event_fifo.sv | 78 +++++++
 rtl/button_scan_controller.sv | 192 +++++++++++++++++++
 tb/tb_button_scan_controller.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/button_scan_pkg.sv
// ---------------------------------------------------------------------------
// button_scan_pkg
// Shared types for the button scan controller and its event queue.
//   scan_state_t : scheduler states (idle between sample ticks, scanning)
//   event_t      : one queued button event, {button index, new level}
//   id_width()   : index width for a given button count (never below 1)
// ---------------------------------------------------------------------------
package button_scan_pkg;

    // Scheduler: idle between sample ticks, then one sweep over all buttons.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } scan_state_t;

    // The id field is sized for the largest supported button count (16) so
    // the struct layout does not depend on the top-level parameters.
    localparam int EVENT_ID_W = 4;

    typedef struct packed {
        logic [EVENT_ID_W-1:0] id;
        logic                  pressed;
    } event_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_scan_controller_event_fifo.sv
// ---------------------------------------------------------------------------
// event_fifo
// Small synchronous FIFO with valid/ready style pop and drop reporting.
//   clk, rst    : clock, asynchronous active-high reset
//   push_valid  : write request; push_data is stored if there is room
//   push_data   : entry to store
//   pop_ready   : consumer takes the head entry (ignored while empty)
//   pop_data    : head entry, meaningful only while empty is low
//   full, empty : occupancy flags
//   drop        : a push was refused because the queue was full and no pop
//                 freed a slot in the same cycle
// ---------------------------------------------------------------------------
module event_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the index bits coincide.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    // A pop in the same cycle frees the slot, so a push into a full queue
    // still succeeds when the consumer is draining.
    assign do_pop  = pop_ready && !empty;
    assign do_push = push_valid && (!full || do_pop);
    assign drop    = push_valid && full && !do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/button_scan_controller.sv
// ---------------------------------------------------------------------------
// button_scan_controller
// Debounces N_BUTTONS raw buttons with one shared compare/count datapath that
// is time-multiplexed over the buttons once per sample period, and queues an
// event for every accepted level change.
//   clk, rst       : clock, asynchronous active-high reset
//   buttons_in     : raw bouncy buttons, asynchronous to clk
//   debounced_out  : accepted stable level per button
//   event_valid    : event queue non-empty
//   event_ready    : consumer accepts the head event
//   event_id       : button index of the head event
//   event_pressed  : head event direction (1 = rose, 0 = fell)
//   overflow       : sticky, an event was dropped because the queue was full
//   clr_overflow   : synchronous clear of overflow (a same-cycle drop wins)
// ---------------------------------------------------------------------------
module button_scan_controller
    import button_scan_pkg::*;
#(
    parameter int N_BUTTONS      = 4,
    parameter int SAMPLE_DIV     = 1000,
    parameter int STABLE_SAMPLES = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_BUTTONS-1:0] buttons_in,
    output logic [N_BUTTONS-1:0] debounced_out,
    output logic                 event_valid,
    input  logic                 event_ready,
    output logic [((N_BUTTONS > 1) ? $clog2(N_BUTTONS) : 1)-1:0] event_id,
    output logic                 event_pressed,
    output logic                 overflow,
    input  logic                 clr_overflow
);

    localparam int ID_W  = id_width(N_BUTTONS);
    localparam int CNT_W = $clog2(STABLE_SAMPLES + 1);
    localparam int PS_W  = $clog2(SAMPLE_DIV);

    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);
    localparam logic [ID_W-1:0]  IDX_LAST = ID_W'(N_BUTTONS - 1);

    logic [N_BUTTONS-1:0] sync1_q, sync1_d;
    logic [N_BUTTONS-1:0] sync2_q, sync2_d;
    logic [PS_W-1:0]      ps_cnt_q, ps_cnt_d;
    logic                 sample_tick;
    scan_state_t          state_q, state_d;
    logic [ID_W-1:0]      scan_idx_q, scan_idx_d;
    logic [N_BUTTONS-1:0] stable_q, stable_d;
    logic [CNT_W-1:0]     dis_cnt_q [N_BUTTONS];
    logic [CNT_W-1:0]     dis_cnt_d [N_BUTTONS];
    logic                 overflow_q, overflow_d;

    logic                 cur_in;
    logic                 cur_stable;
    logic [CNT_W-1:0]     cur_cnt;
    logic                 ev_push;
    event_t               ev_data;
    event_t               head;
    logic [$bits(event_t)-1:0] head_bits;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_drop;
    logic [EVENT_ID_W:0]  unused_bits;

    // Two-flop synchronizer; only sync2 is ever looked at by the datapath.
    always_comb begin
        sync1_d = buttons_in;
        sync2_d = sync1_q;
    end

    // Free-running prescaler; the tick marks the last count of each period.
    assign sample_tick = (ps_cnt_q == PS_LAST);

    always_comb begin
        ps_cnt_d = sample_tick ? '0 : ps_cnt_q + PS_W'(1);
    end

    // Scheduler: each tick starts a sweep that visits one button per cycle.
    // SAMPLE_DIV >= N_BUTTONS+1 guarantees a sweep ends before the next tick.
    always_comb begin
        state_d    = state_q;
        scan_idx_d = scan_idx_q;
        case (state_q)
            S_IDLE: begin
                if (sample_tick) begin
                    state_d    = S_SCAN;
                    scan_idx_d = '0;
                end
            end
            S_SCAN: begin
                if (scan_idx_q == IDX_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    scan_idx_d = scan_idx_q + ID_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Shared compare/count datapath for the visited button. A level change
    // is accepted only after STABLE_SAMPLES consecutive disagreeing visits;
    // any agreeing visit restarts the count.
    always_comb begin
        cur_in     = sync2_q[scan_idx_q];
        cur_stable = stable_q[scan_idx_q];
        cur_cnt    = dis_cnt_q[scan_idx_q];
        stable_d   = stable_q;
        dis_cnt_d  = dis_cnt_q;
        ev_push    = 1'b0;
        ev_data    = '0;
        if (state_q == S_SCAN) begin
            if (cur_in == cur_stable) begin
                dis_cnt_d[scan_idx_q] = '0;
            end else if (cur_cnt == CNT_LAST) begin
                stable_d[scan_idx_q]  = cur_in;
                dis_cnt_d[scan_idx_q] = '0;
                ev_push               = 1'b1;
            end else begin
                dis_cnt_d[scan_idx_q] = cur_cnt + CNT_W'(1);
            end
        end
        ev_data.id      = EVENT_ID_W'(scan_idx_q);
        ev_data.pressed = cur_in;
    end

    // Sticky overflow: a drop in the same cycle as a clear keeps it set.
    always_comb begin
        overflow_d = overflow_q;
        if (clr_overflow) begin
            overflow_d = 1'b0;
        end
        if (fifo_drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            ps_cnt_q   <= '0;
            state_q    <= S_IDLE;
            scan_idx_q <= '0;
            stable_q   <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < N_BUTTONS; i++) begin
                dis_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            ps_cnt_q   <= ps_cnt_d;
            state_q    <= state_d;
            scan_idx_q <= scan_idx_d;
            stable_q   <= stable_d;
            overflow_q <= overflow_d;
            dis_cnt_q  <= dis_cnt_d;
        end
    end

    event_fifo #(
        .WIDTH ($bits(event_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_event_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (ev_push),
        .push_data  (ev_data),
        .pop_ready  (event_ready),
        .pop_data   (head_bits),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .drop       (fifo_drop)
    );

    assign head = event_t'(head_bits);

    // Head fields are forced to zero while the queue is empty so stale
    // storage never leaks onto the outputs.
    assign debounced_out = stable_q;
    assign event_valid   = !fifo_empty;
    assign event_id      = fifo_empty ? '0 : head.id[ID_W-1:0];
    assign event_pressed = !fifo_empty && head.pressed;
    assign overflow      = overflow_q;

    // Full flag and the upper id bits are not needed at this level.
    assign unused_bits = {fifo_full, head.id};

endmodule

// File: tb/tb_button_scan_controller.sv
// ---------------------------------------------------------------------------
// tb_button_scan_controller
// Directed bench for button_scan_controller with N_BUTTONS=4, SAMPLE_DIV=8,
// STABLE_SAMPLES=3, FIFO_DEPTH=2. Stimulus pushes expected events into a
// scoreboard queue; a monitor pops and compares whenever the DUT hands an
// event to the consumer. Level/flag expectations are checked directly.
// ---------------------------------------------------------------------------
module tb_button_scan_controller;

    localparam int NB = 4;
    localparam int SD = 8;
    localparam int SS = 3;
    localparam int FD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] buttons_in = 4'b0000;
    logic       event_ready = 1'b0;
    logic       clr_overflow = 1'b0;
    logic [3:0] debounced_out;
    logic       event_valid;
    logic [1:0] event_id;
    logic       event_pressed;
    logic       overflow;

    int         checks = 0;
    int         errors = 0;
    logic [2:0] exp_q[$];
    logic [2:0] mon_exp;
    int         phase;

    button_scan_controller #(
        .N_BUTTONS      (NB),
        .SAMPLE_DIV     (SD),
        .STABLE_SAMPLES (SS),
        .FIFO_DEPTH     (FD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .buttons_in    (buttons_in),
        .debounced_out (debounced_out),
        .event_valid   (event_valid),
        .event_ready   (event_ready),
        .event_id      (event_id),
        .event_pressed (event_pressed),
        .overflow      (overflow),
        .clr_overflow  (clr_overflow)
    );

    always #5 clk = ~clk;

    // Position inside the sample period: the prescaler value after reset.
    // Button i is visited in the cycle where this equals i.
    always @(posedge clk or posedge rst) begin
        if (rst) phase <= 0;
        else     phase <= (phase + 1) % SD;
    end

    // Scoreboard monitor: an event is consumed when valid and ready are
    // both high at the next rising edge.
    always @(negedge clk) begin
        if (!rst && event_valid && event_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL event_pop: got id=%0d pressed=%0d, expected no event",
                         event_id, event_pressed);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({event_id, event_pressed} !== mon_exp) begin
                    errors++;
                    $display("[TB] FAIL event_pop: got id=%0d pressed=%0d, expected id=%0d pressed=%0d",
                             event_id, event_pressed, mon_exp[2:1], mon_exp[0]);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [3:0] b, input logic rdy, input logic clr);
        buttons_in   = b;
        event_ready  = rdy;
        clr_overflow = clr;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expectEvent(input int id, input logic pressed);
        exp_q.push_back({2'(id), pressed});
    endtask

    task automatic alignPhase(input int p);
        int guard = 0;
        while (phase != p && guard < 2 * SD) begin
            tick(1);
            guard++;
        end
    endtask

    task automatic waitDebounced(input logic [3:0] want, input int budget, input string name);
        int n = 0;
        while (debounced_out !== want && n < budget) begin
            tick(1);
            n++;
        end
        checkOutput(name, debounced_out, want);
    endtask

    task automatic popOne(input logic [3:0] b);
        applyStimulus(b, 1'b1, 1'b0);
        tick(1);
        applyStimulus(b, 1'b0, 1'b0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_debounced"}, debounced_out, 0);
        checkOutput({tag, "_valid"}, event_valid, 0);
        checkOutput({tag, "_id"}, event_id, 0);
        checkOutput({tag, "_pressed"}, event_pressed, 0);
        checkOutput({tag, "_overflow"}, overflow, 0);
    endtask

    initial begin
        applyStimulus(4'b0000, 1'b0, 1'b0);
        rst = 1'b1;
        tick(3);
        checkAllZero("reset");
        rst = 1'b0;

        // Idle inputs for 100 cycles: nothing happens.
        tick(100);
        checkOutput("idle_debounced", debounced_out, 0);
        checkOutput("idle_valid", event_valid, 0);
        checkOutput("idle_overflow", overflow, 0);

        // Single press of button 1, consumer not ready.
        alignPhase(4);
        applyStimulus(4'b0010, 1'b0, 1'b0);
        expectEvent(1, 1'b1);
        waitDebounced(4'b0010, 32, "press1_debounced");
        checkOutput("press1_valid", event_valid, 1);
        checkOutput("press1_id", event_id, 1);
        checkOutput("press1_pressed", event_pressed, 1);
        tick(20);
        checkOutput("press1_valid_held", event_valid, 1);
        popOne(4'b0010);
        checkOutput("press1_valid_after_pop", event_valid, 0);

        // Button 2 toggles once per sample period: never three agreeing
        // disagreements in a row, so it must never be accepted.
        alignPhase(4);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(buttons_in ^ 4'b0100, 1'b0, 1'b0);
            tick(8);
        end
        tick(40);
        checkOutput("bounce_debounced", debounced_out, 4'b0010);
        checkOutput("bounce_valid", event_valid, 0);

        // Release button 1 to start the overflow scenario from all-released.
        alignPhase(4);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        expectEvent(1, 1'b0);
        waitDebounced(4'b0000, 32, "release1_debounced");
        popOne(4'b0000);
        checkOutput("release1_valid_after_pop", event_valid, 0);

        // Press 0, 1, 3 one sample period apart; the third event overflows.
        alignPhase(4);
        applyStimulus(4'b0001, 1'b0, 1'b0);
        expectEvent(0, 1'b1);
        tick(8);
        applyStimulus(4'b0011, 1'b0, 1'b0);
        expectEvent(1, 1'b1);
        tick(8);
        applyStimulus(4'b1011, 1'b0, 1'b0);
        tick(40);
        checkOutput("ovf_debounced", debounced_out, 4'b1011);
        checkOutput("ovf_flag", overflow, 1);
        checkOutput("ovf_valid", event_valid, 1);
        checkOutput("ovf_head_id", event_id, 0);
        applyStimulus(4'b1011, 1'b0, 1'b1);
        tick(1);
        applyStimulus(4'b1011, 1'b0, 1'b0);
        checkOutput("ovf_cleared", overflow, 0);
        checkOutput("ovf_queue_kept", event_valid, 1);
        applyStimulus(4'b1011, 1'b1, 1'b0);
        tick(2);
        applyStimulus(4'b1011, 1'b0, 1'b0);
        checkOutput("ovf_drained", event_valid, 0);

        // Release 0, 1, 3 together: 0 and 1 fill the queue, 3 arrives two
        // cycles later while the consumer pops in exactly that cycle.
        alignPhase(4);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        expectEvent(0, 1'b0);
        expectEvent(1, 1'b0);
        expectEvent(3, 1'b0);
        tick(22);
        checkOutput("full_debounced", debounced_out, 4'b1000);
        checkOutput("full_valid", event_valid, 1);
        checkOutput("full_overflow", overflow, 0);
        tick(1);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        tick(1);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("pushpop_overflow", overflow, 0);
        checkOutput("pushpop_debounced", debounced_out, 4'b0000);
        checkOutput("pushpop_valid", event_valid, 1);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        tick(2);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("pushpop_drained", event_valid, 0);

        // Reset during a sweep with one event queued.
        alignPhase(4);
        applyStimulus(4'b0100, 1'b0, 1'b0);
        expectEvent(2, 1'b1);
        tick(29);
        checkOutput("prerst_valid", event_valid, 1);
        checkOutput("prerst_debounced", debounced_out, 4'b0100);
        rst = 1'b1;
        exp_q.delete();
        tick(1);
        checkAllZero("midrst");
        rst = 1'b0;
        expectEvent(2, 1'b1);
        waitDebounced(4'b0100, 40, "rearm_debounced");
        checkOutput("rearm_valid", event_valid, 1);
        checkOutput("rearm_id", event_id, 2);
        checkOutput("rearm_pressed", event_pressed, 1);
        popOne(4'b0100);
        checkOutput("rearm_valid_after_pop", event_valid, 0);
        checkOutput("scoreboard_left", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
